ins_mem: RTL and testbench
==========================

# ins_mem

Word-addressed instruction memory for the single-cycle datapath. It returns the 32-bit instruction at the current program counter combinationally, so fetch completes within the same cycle the PC is presented. Contents come from two sources: a built-in boot program, restored on reset, and a synchronous load port used by test benches and the loader to overwrite words.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words (power of two, 16 to 65536).
- AW, clog2(DEPTH): internal index width.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- pc  input  16  word address (pc = 1 selects the second word; not byte-addressed).
- instruction  output  32  word at pc, combinational.
- addr_err  output  1  high when pc >= DEPTH, combinational.
- load_en  input  1  write strobe for the load port.
- load_addr  input  16  word address to write.
- load_data  input  32  data to write.

## Operation
Read path:
- instruction = mem[pc] when pc < DEPTH.
- When pc >= DEPTH: instruction = 32'h0000_0000 (NOP) and addr_err = 1.
- No clock involvement; output follows pc and memory contents.

Reset (rst_n low at a rising edge):
- Words 0–5 take the boot program:
  - 0: 32'h0000_0000
  - 1: 32'h2001_0005
  - 2: 32'h2002_0003
  - 3: 32'h0022_1820
  - 4: 32'hAC03_0000
  - 5: 32'h0800_0000
- All remaining words become 0.
- Reset has priority over load_en in the same cycle.

Load (rst_n high, load_en high at a rising edge):
- mem[load_addr] <= load_data.
- If load_addr >= DEPTH, the write is dropped and no word changes.

Contents before the first reset are undefined. Benches must apply reset first.

## Timing
- Read latency is 0 cycles. instruction and addr_err settle within combinational delay of a change on pc or of the memory update at a clock edge.
- Read-during-write to the same address:
  - Before the edge, the old word is returned.
  - After the edge, the new word is returned.
  - No bypass.
- Reset takes effect at the first rising edge with rst_n low. After that edge instruction reflects the boot program.
- Reset asserted mid-load sequence discards any load sampled on the same edge. Earlier loads are overwritten by the boot image.
- addr_err is combinational only, not registered. There is no reset value beyond being a function of pc.

## Structure
- Shared package: DEPTH default, NOP constant 32'h0, boot-program word constants and BOOT_LEN = 6.
- One natural sub-module, ins_mem_boot_rom: pure combinational function mapping index to boot word. The main block uses it to drive the reset loop.
- Main block contents:
  - memory array;
  - reset/load write process;
  - range check;
  - read mux.

## Test plan
- Reset, then sweep pc 0→5 holding each 50 ns. Required instruction sequence: 0, 2001_0005, 2002_0003, 0022_1820, AC03_0000, 0800_0000. addr_err = 0 throughout.
- After reset, pc = 6 and pc = DEPTH−1 -> instruction = 0, addr_err = 0. pc = DEPTH and pc = 16'hFFFF -> instruction = 0, addr_err = 1.
- Load 32'hDEAD_BEEF to address 10 with pc = 10 held:
  - instruction = 0 before the edge;
  - instruction = DEAD_BEEF after the edge;
  - word 9 and word 11 are still 0.
- Load to load_addr = DEPTH with data 32'h1234_5678, then sweep all addresses -> no word changed.
- Load 32'hCAFE_F00D to address 1, then assert rst_n low with load_en high, load_addr = 2, load_data = 32'h1111_1111 on the same edge:
  - pc = 1 reads 2001_0005;
  - pc = 2 reads 2002_0003.
- Back-to-back loads to addresses 3 then 3 on consecutive edges (values A, B) -> after the second edge pc = 3 reads B.

Source files
------------

// File: rtl/ins_mem_pkg.sv
// Shared constants for the instruction memory: default depth, NOP encoding
// and the boot program image restored on reset.
package ins_mem_pkg;

    localparam int DEPTH_DEFAULT = 256;

    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam int BOOT_LEN = 6;
    localparam int BOOT_IW  = 3;

    localparam logic [31:0] BOOT_W0 = 32'h0000_0000;
    localparam logic [31:0] BOOT_W1 = 32'h2001_0005;
    localparam logic [31:0] BOOT_W2 = 32'h2002_0003;
    localparam logic [31:0] BOOT_W3 = 32'h0022_1820;
    localparam logic [31:0] BOOT_W4 = 32'hAC03_0000;
    localparam logic [31:0] BOOT_W5 = 32'h0800_0000;

endpackage

// File: rtl/ins_mem_boot_rom.sv
// Boot program lookup: maps a boot-image index to its instruction word.
// Indices past the end of the image return NOP.
module ins_mem_boot_rom
    import ins_mem_pkg::*;
(
    input  logic [BOOT_IW-1:0] idx,
    output logic [31:0]        word
);

    // Pure table lookup of the boot image
    always_comb begin
        word = NOP;
        case (idx)
            3'd0:    word = BOOT_W0;
            3'd1:    word = BOOT_W1;
            3'd2:    word = BOOT_W2;
            3'd3:    word = BOOT_W3;
            3'd4:    word = BOOT_W4;
            3'd5:    word = BOOT_W5;
            default: word = NOP;
        endcase
    end

endmodule

// File: rtl/ins_mem.sv
// Word-addressed instruction memory with a zero-latency read port, a
// synchronous load port and a boot image restored by synchronous reset.
module ins_mem
    import ins_mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    output logic [31:0] instruction,
    output logic        addr_err,
    input  logic        load_en,
    input  logic [15:0] load_addr,
    input  logic [31:0] load_data
);

    // DEPTH may be 65536, which does not fit in 16 bits
    localparam logic [16:0] DEPTH_C = 17'(DEPTH);

    logic [31:0] mem [DEPTH];
    logic [31:0] boot_words [BOOT_LEN];
    logic        pc_ok;
    logic        load_ok;

    // One ROM lookup per boot word so the reset loop can load them in parallel
    for (genvar g = 0; g < BOOT_LEN; g++) begin : g_boot
        ins_mem_boot_rom u_rom (
            .idx  (BOOT_IW'(g)),
            .word (boot_words[g])
        );
    end

    // Range checks for the read and load addresses
    always_comb begin
        pc_ok   = ({1'b0, pc} < DEPTH_C);
        load_ok = ({1'b0, load_addr} < DEPTH_C);
    end

    // Reset restores the boot image (later NBAs override the clear); reset beats load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= NOP;
            end
            for (int j = 0; j < BOOT_LEN; j++) begin
                mem[j] <= boot_words[j];
            end
        end else if (load_en && load_ok) begin
            mem[load_addr[AW-1:0]] <= load_data;
        end
    end

    // Combinational read; out-of-range fetches return NOP and flag the error
    always_comb begin
        instruction = NOP;
        addr_err    = !pc_ok;
        if (pc_ok) begin
            instruction = mem[pc[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_ins_mem.sv
// Scoreboard bench for ins_mem: each stimulus cycle pushes the expected read
// (from an array model) into a queue; a monitor on the falling edge pops and
// compares against the DUT outputs.
module tb_ins_mem;

    localparam int DEPTH = 256;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc;
    logic [31:0] instruction;
    logic        addr_err;
    logic        load_en;
    logic [15:0] load_addr;
    logic [31:0] load_data;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] ins;
        logic        err;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [DEPTH];
    bit          model_ok;
    int          checks;
    int          errors;

    ins_mem #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .instruction (instruction),
        .addr_err    (addr_err),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        logic [31:0] boot [6];
        boot = '{32'h0000_0000, 32'h2001_0005, 32'h2002_0003,
                 32'h0022_1820, 32'hAC03_0000, 32'h0800_0000};
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        for (int i = 0; i < 6; i++) ref_mem[i] = boot[i];
        model_ok = 1'b1;
    endfunction

    // One clock cycle: drive inputs, queue the pre-edge expectation, then
    // apply the edge's effect to the model.
    task automatic cycle(input logic r, input logic le, input logic [15:0] la,
                         input logic [31:0] ld, input logic [15:0] p, input string nm);
        exp_t e;
        rst_n = r; load_en = le; load_addr = la; load_data = ld; pc = p;
        if (model_ok) begin
            e.pc   = p;
            e.err  = (int'(p) >= DEPTH);
            e.ins  = e.err ? 32'h0 : ref_mem[p];
            e.name = nm;
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (!r) model_reset();
        else if (le && int'(la) < DEPTH) ref_mem[la] = ld;
        #1;
    endtask

    task automatic read(input logic [15:0] p, input string nm);
        cycle(1'b1, 1'b0, 16'h0, 32'h0, p, nm);
    endtask

    // Monitor: compare whatever expectation is pending against the DUT
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || instruction !== e.ins || addr_err !== e.err) begin
                errors++;
                $display("FAIL %s pc=%h: got ins=%h err=%b, expected ins=%h err=%b",
                         e.name, e.pc, instruction, addr_err, e.ins, e.err);
            end
        end
    end

    initial begin
        checks = 0; errors = 0; model_ok = 1'b0;
        rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; pc = '0;
        @(posedge clk); #1;
        cycle(1'b0, 1'b0, 16'h0, 32'h0, 16'h0, "reset");

        for (int a = 0; a < 6; a++)
            for (int h = 0; h < 5; h++) read(16'(a), "boot_sweep");

        read(16'd6, "pc6");
        read(16'(DEPTH - 1), "pc_last");
        read(16'(DEPTH), "pc_depth");
        read(16'hFFFF, "pc_ffff");

        cycle(1'b1, 1'b1, 16'd10, 32'hDEAD_BEEF, 16'd10, "rdw_before");
        read(16'd10, "rdw_after");
        read(16'd9, "neighbour9");
        read(16'd11, "neighbour11");

        cycle(1'b1, 1'b1, 16'(DEPTH), 32'h1234_5678, 16'(DEPTH), "oob_load");
        for (int a = 0; a < DEPTH; a++) read(16'(a), "oob_sweep");

        cycle(1'b1, 1'b1, 16'd1, 32'hCAFE_F00D, 16'd1, "pre_rst_load");
        read(16'd1, "loaded1");
        cycle(1'b0, 1'b1, 16'd2, 32'h1111_1111, 16'd2, "rst_vs_load");
        read(16'd1, "after_rst1");
        read(16'd2, "after_rst2");

        cycle(1'b1, 1'b1, 16'd3, 32'hAAAA_0001, 16'd3, "b2b_first");
        cycle(1'b1, 1'b1, 16'd3, 32'hBBBB_0002, 16'd3, "b2b_second");
        read(16'd3, "b2b_result");

        for (int n = 0; n < 400; n++) begin
            logic        r, le;
            logic [15:0] la, p;
            r  = ($urandom_range(0, 49) != 0);
            le = $urandom_range(0, 1) == 1;
            la = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, DEPTH - 1));
            p  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            cycle(r, le, la, $urandom, p, "random");
        end

        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
